mem_row_reader: RTL and testbench

Read-back engine for the day-4 grid memory. On a `run` pulse it walks rows `START_ROW` through `END_ROW-1`. For each row it fetches every `TX_DATA_WIDTH`-wide column chunk from the `mem` bank using the bank's read request/ack handshake. It serialises the chunk bits into an ASCII character stream (`@`/`.` per cell, LF per row) with valid/ready backpressure, and it counts occupied cells. This is the reader counterpart to the bank loader. It dumps the grid after the free-roll machines have finished updating it.

---
 rtl/mem_row_reader.sv | 229 ++++++++++++++++++++++
 tb/tb_mem_row_reader.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_row_reader.sv
// rtl/mem_row_reader.sv - grid read-back engine: bank fetch, ASCII serialiser, '@' counter
//
// Purpose:
//   On a run pulse, walks rows START_ROW..END_ROW-1. For each row it fetches
//   every TX_W-wide column chunk from the bank using a request/ack handshake.
//   Each valid cell is emitted as '@' (bit set) or '.' (bit clear), and every
//   row is terminated with LF. The engine also counts the '@' cells it emits.
//
// Ports:
//   clock, reset          - rising-edge clock, asynchronous active-low reset
//   run                   - start pulse, honoured only in IDLE
//   read_en_out           - bank read request, held until ack is sampled high
//   row_addr_out          - row address of the current request
//   col_addr_out          - chunk base column of the current request
//   ack_in                - bank ack; read data is valid while it is high
//   partial_vec_in        - bank read data; bit i is column col_addr_out+i
//   char_out, char_valid  - character stream output
//   char_ready            - character stream backpressure
//   busy_out              - high whenever the engine is not idle
//   roll_count_out        - saturating count of '@' emitted since the last run
//   done_out              - one-cycle pulse at the end of the dump
module mem_row_reader #(
    parameter int TX_W      = 8,
    parameter int ROW_AW    = 4,
    parameter int COL_AW    = 4,
    parameter int NUM_COLS  = 10,
    parameter int START_ROW = 0,
    parameter int END_ROW   = 2,
    parameter int CNT_W     = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    input  logic              ack_in,
    input  logic [TX_W-1:0]   partial_vec_in,
    output logic              read_en_out,
    output logic [ROW_AW-1:0] row_addr_out,
    output logic [COL_AW-1:0] col_addr_out,
    output logic [7:0]        char_out,
    output logic              char_valid,
    input  logic              char_ready,
    output logic              busy_out,
    output logic [CNT_W-1:0]  roll_count_out,
    output logic              done_out
);

    localparam int         BIT_W       = (TX_W > 1) ? $clog2(TX_W) : 1;
    localparam bit         EMPTY_RANGE = (START_ROW >= END_ROW);
    localparam logic [7:0] CH_AT       = 8'h40;
    localparam logic [7:0] CH_DOT      = 8'h2E;
    localparam logic [7:0] CH_LF       = 8'h0A;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RELEASE,
        S_EMIT,
        S_EOL,
        S_DONE
    } state_t;

    state_t            r_state,      w_state_nxt;
    logic [ROW_AW-1:0] r_row,        w_row_nxt;
    logic [COL_AW-1:0] r_col,        w_col_nxt;
    logic [TX_W-1:0]   r_shift,      w_shift_nxt;
    logic [BIT_W-1:0]  r_bit,        w_bit_nxt;
    logic [CNT_W-1:0]  r_count,      w_count_nxt;
    logic              r_read_en,    w_read_en_nxt;
    logic [7:0]        r_char,       w_char_nxt;
    logic              r_char_valid, w_char_valid_nxt;
    logic              r_done,       w_done_nxt;
    logic              r_busy,       w_busy_nxt;

    logic              w_handshake;
    logic [TX_W-1:0]   w_shift_next_bit;
    logic [31:0]       w_abs_col;
    logic              w_last_bit;
    logic              w_more_chunks;
    logic [31:0]       w_row_inc;
    logic              w_last_row;
    logic [CNT_W-1:0]  w_count_inc;

    assign w_handshake      = r_char_valid & char_ready;
    // The next cell to emit always sits at bit 0 once the register is shifted.
    assign w_shift_next_bit = r_shift >> 1;
    assign w_abs_col        = 32'(r_col) + 32'(r_bit);
    // A chunk ends at its top bit or at the last valid column, whichever is first,
    // so padding bits beyond NUM_COLS are never emitted or counted.
    assign w_last_bit       = (r_bit == BIT_W'(TX_W - 1)) || (w_abs_col == 32'(NUM_COLS - 1));
    assign w_more_chunks    = (32'(r_col) + 32'(TX_W)) < 32'(NUM_COLS);
    assign w_row_inc        = 32'(r_row) + 32'd1;
    assign w_last_row       = (w_row_inc == 32'(END_ROW));
    assign w_count_inc      = (r_count == {CNT_W{1'b1}}) ? r_count : r_count + CNT_W'(1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_row        <= '0;
            r_col        <= '0;
            r_shift      <= '0;
            r_bit        <= '0;
            r_count      <= '0;
            r_read_en    <= 1'b0;
            r_char       <= '0;
            r_char_valid <= 1'b0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_row        <= w_row_nxt;
            r_col        <= w_col_nxt;
            r_shift      <= w_shift_nxt;
            r_bit        <= w_bit_nxt;
            r_count      <= w_count_nxt;
            r_read_en    <= w_read_en_nxt;
            r_char       <= w_char_nxt;
            r_char_valid <= w_char_valid_nxt;
            r_done       <= w_done_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_row_nxt        = r_row;
        w_col_nxt        = r_col;
        w_shift_nxt      = r_shift;
        w_bit_nxt        = r_bit;
        w_count_nxt      = r_count;
        w_read_en_nxt    = r_read_en;
        w_char_nxt       = r_char;
        w_char_valid_nxt = r_char_valid;
        w_done_nxt       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_row_nxt   = ROW_AW'(START_ROW);
                    w_col_nxt   = '0;
                    w_count_nxt = '0;
                    if (EMPTY_RANGE) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt   = S_REQ;
                        w_read_en_nxt = 1'b1;
                    end
                end
            end

            S_REQ: begin
                if (ack_in) begin
                    w_shift_nxt   = partial_vec_in;
                    w_read_en_nxt = 1'b0;
                    w_state_nxt   = S_RELEASE;
                end
            end

            // Wait for the bank to drop ack so a long ack is never taken as a
            // response to the next request.
            S_RELEASE: begin
                if (!ack_in) begin
                    w_state_nxt      = S_EMIT;
                    w_bit_nxt        = '0;
                    w_char_valid_nxt = 1'b1;
                    w_char_nxt       = r_shift[0] ? CH_AT : CH_DOT;
                end
            end

            S_EMIT: begin
                if (w_handshake) begin
                    if (r_shift[0]) begin
                        w_count_nxt = w_count_inc;
                    end
                    if (w_last_bit) begin
                        if (w_more_chunks) begin
                            w_col_nxt        = r_col + COL_AW'(TX_W);
                            w_state_nxt      = S_REQ;
                            w_read_en_nxt    = 1'b1;
                            w_char_valid_nxt = 1'b0;
                        end else begin
                            w_state_nxt = S_EOL;
                            w_char_nxt  = CH_LF;
                        end
                    end else begin
                        w_shift_nxt = w_shift_next_bit;
                        w_bit_nxt   = r_bit + BIT_W'(1);
                        w_char_nxt  = w_shift_next_bit[0] ? CH_AT : CH_DOT;
                    end
                end
            end

            S_EOL: begin
                if (w_handshake) begin
                    w_row_nxt        = w_row_inc[ROW_AW-1:0];
                    w_col_nxt        = '0;
                    w_char_valid_nxt = 1'b0;
                    if (w_last_row) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt   = S_REQ;
                        w_read_en_nxt = 1'b1;
                    end
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    assign read_en_out    = r_read_en;
    assign row_addr_out   = r_row;
    assign col_addr_out   = r_col;
    assign char_out       = r_char;
    assign char_valid     = r_char_valid;
    assign busy_out       = r_busy;
    assign roll_count_out = r_count;
    assign done_out       = r_done;

endmodule

// File: tb/tb_mem_row_reader.sv
// tb/tb_mem_row_reader.sv - scoreboard bench for mem_row_reader
module tb_mem_row_reader;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b0;
    logic        ack_in = 1'b0;
    logic [7:0]  partial_vec_in = 8'h00;
    logic        read_en_out;
    logic [3:0]  row_addr_out;
    logic [3:0]  col_addr_out;
    logic [7:0]  char_out;
    logic        char_valid;
    logic        char_ready = 1'b1;
    logic        busy_out;
    logic [31:0] roll_count_out;
    logic        done_out;

    logic        run_b = 1'b0;
    logic        ack_b = 1'b0;
    logic [7:0]  pv_b = 8'hFF;
    logic        ready_b = 1'b1;
    logic        read_en_b;
    logic [3:0]  row_b;
    logic [3:0]  col_b;
    logic [7:0]  char_b;
    logic        char_valid_b;
    logic        busy_b;
    logic [31:0] count_b;
    logic        done_b;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [0:15][0:1];
    logic [7:0] exp_q [$];
    int         req_rows [$];
    int         req_cols [$];

    int         bank_delay = 0;
    int         bank_hold = 1;
    int         bstate = 0;
    int         bcnt = 0;
    int         bhold = 0;
    logic [7:0] bdata = 8'h00;
    logic       last_ack = 1'b0;
    logic       prev_ren = 1'b0;
    int         captures = 0;
    int         viol = 0;

    bit         rand_ready = 1'b0;
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_char = 8'h00;
    logic [7:0] exp_ch;
    int         stab_err = 0;
    int         b_activity = 0;

    always #5 clock = ~clock;

    mem_row_reader #(
        .TX_W(8), .ROW_AW(4), .COL_AW(4), .NUM_COLS(10),
        .START_ROW(0), .END_ROW(2), .CNT_W(32)
    ) dut (
        .clock(clock), .reset(reset), .run(run), .ack_in(ack_in),
        .partial_vec_in(partial_vec_in), .read_en_out(read_en_out),
        .row_addr_out(row_addr_out), .col_addr_out(col_addr_out),
        .char_out(char_out), .char_valid(char_valid), .char_ready(char_ready),
        .busy_out(busy_out), .roll_count_out(roll_count_out), .done_out(done_out)
    );

    mem_row_reader #(
        .TX_W(8), .ROW_AW(4), .COL_AW(4), .NUM_COLS(10),
        .START_ROW(4), .END_ROW(4), .CNT_W(32)
    ) dut_empty (
        .clock(clock), .reset(reset), .run(run_b), .ack_in(ack_b),
        .partial_vec_in(pv_b), .read_en_out(read_en_b),
        .row_addr_out(row_b), .col_addr_out(col_b),
        .char_out(char_b), .char_valid(char_valid_b), .char_ready(ready_b),
        .busy_out(busy_b), .roll_count_out(count_b), .done_out(done_b)
    );

    // Bank model: ack after bank_delay cycles, held for bank_hold cycles.
    // Data past the first ack cycle is inverted so a late recapture shows up.
    always @(negedge clock) begin
        last_ack = ack_in;
        if (!reset) begin
            bstate = 0;
            ack_in = 1'b0;
        end else begin
            if (read_en_out && !prev_ren && last_ack) viol++;
            case (bstate)
                0: if (read_en_out) begin
                    req_rows.push_back(int'(row_addr_out));
                    req_cols.push_back(int'(col_addr_out));
                    bdata  = mem[row_addr_out][col_addr_out >> 3];
                    bcnt   = bank_delay;
                    bstate = 1;
                end
                1: if (bcnt == 0) begin
                    ack_in         = 1'b1;
                    partial_vec_in = bdata;
                    bhold          = bank_hold;
                    bstate         = 2;
                end else begin
                    bcnt--;
                end
                default: begin
                    partial_vec_in = ~bdata;
                    bhold--;
                    if (bhold == 0) begin
                        ack_in         = 1'b0;
                        partial_vec_in = 8'h5A;
                        bstate         = 0;
                    end
                end
            endcase
            if (read_en_out && ack_in) captures++;
        end
        prev_ren = read_en_out;
    end

    // Character sink and scoreboard pop.
    always @(negedge clock) begin
        if (!reset) begin
            prev_valid = 1'b0;
            char_ready = 1'b1;
        end else begin
            if (prev_valid && !prev_ready && (!char_valid || char_out !== prev_char)) stab_err++;
            char_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            prev_ready = char_ready;
            prev_valid = char_valid;
            prev_char  = char_out;
            if (char_valid && char_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL char_stream: got %02h, no character expected", char_out);
                end else begin
                    exp_ch = exp_q.pop_front();
                    if (char_out !== exp_ch) begin
                        errors++;
                        $display("FAIL char_stream: got %02h, expected %02h", char_out, exp_ch);
                    end
                end
            end
        end
        if (read_en_b || char_valid_b) b_activity++;
    end

    task automatic clear_stats();
        req_rows.delete();
        req_cols.delete();
        captures = 0;
        viol     = 0;
        stab_err = 0;
    endtask

    task automatic push_expected();
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 10; c++) begin
                exp_q.push_back(mem[r][c / 8][c % 8] ? 8'h40 : 8'h2E);
            end
            exp_q.push_back(8'h0A);
        end
    endtask

    task automatic start_run(input string name);
        @(negedge clock);
        run = 1'b1;
        @(negedge clock);
        run = 1'b0;
        checks++;
        if (read_en_out !== 1'b1) begin
            errors++;
            $display("FAIL %s_req_latency: read_en_out=%b, expected 1", name, read_en_out);
        end
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clock);
            if (done_out) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_done: done_out not seen in 4000 cycles, expected pulse", name);
        end
    endtask

    task automatic check_run_result(input string name);
        bit ok;
        checks++;
        if (roll_count_out !== 32'd3) begin
            errors++;
            $display("FAIL %s_count: roll_count_out=%0d, expected 3", name, roll_count_out);
        end
        checks++;
        if (busy_out !== 1'b1) begin
            errors++;
            $display("FAIL %s_busy_at_done: busy_out=%b, expected 1", name, busy_out);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_stream_len: %0d characters missing, expected 0", name, exp_q.size());
        end
        ok = (req_rows.size() == 4);
        if (ok) begin
            for (int i = 0; i < 4; i++) begin
                if (req_rows[i] != i / 2 || req_cols[i] != (i % 2) * 8) ok = 1'b0;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_requests: %0d requests with wrong addresses, expected rows 0,0,1,1 cols 0,8,0,8",
                     name, req_rows.size());
        end
        checks++;
        if (captures != 4) begin
            errors++;
            $display("FAIL %s_captures: %0d ack captures, expected 4", name, captures);
        end
        @(negedge clock);
        checks++;
        if (done_out !== 1'b0 || busy_out !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_pulse: done=%b busy=%b, expected 0 0", name, done_out, busy_out);
        end
        repeat (5) @(negedge clock);
        checks++;
        if (roll_count_out !== 32'd3 || busy_out !== 1'b0) begin
            errors++;
            $display("FAIL %s_hold: count=%0d busy=%b, expected 3 0", name, roll_count_out, busy_out);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if ({read_en_out, char_valid, done_out, busy_out, row_addr_out, col_addr_out,
             char_out, roll_count_out} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: en=%b v=%b d=%b b=%b row=%0d col=%0d ch=%02h cnt=%0d, expected all 0",
                     read_en_out, char_valid, done_out, busy_out, row_addr_out, col_addr_out,
                     char_out, roll_count_out);
        end
        checks++;
        if ({read_en_b, char_valid_b, done_b, busy_b, row_b, col_b, char_b, count_b} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_empty: en=%b v=%b d=%b b=%b, expected all 0",
                     read_en_b, char_valid_b, done_b, busy_b);
        end
        reset = 1'b1;
    endtask

    task automatic test_basic_stream();
        bank_delay = 0;
        bank_hold  = 1;
        rand_ready = 1'b0;
        clear_stats();
        push_expected();
        start_run("basic");
        wait_done("basic");
        check_run_result("basic");
    endtask

    task automatic test_random_ready();
        rand_ready = 1'b1;
        clear_stats();
        push_expected();
        start_run("rand_ready");
        wait_done("rand_ready");
        check_run_result("rand_ready");
        checks++;
        if (stab_err != 0) begin
            errors++;
            $display("FAIL rand_ready_stable: %0d unstable stalled characters, expected 0", stab_err);
        end
        rand_ready = 1'b0;
    endtask

    task automatic test_slow_bank();
        bank_delay = 5;
        bank_hold  = 3;
        clear_stats();
        push_expected();
        start_run("slow_bank");
        wait_done("slow_bank");
        check_run_result("slow_bank");
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL slow_bank_rerequest: %0d requests while ack high, expected 0", viol);
        end
        bank_delay = 0;
        bank_hold  = 1;
    endtask

    task automatic test_empty_range();
        bit seen;
        seen = 1'b0;
        @(negedge clock);
        run_b = 1'b1;
        @(negedge clock);
        run_b = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done_b) begin
                seen = 1'b1;
                break;
            end
            @(negedge clock);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL empty_done: done_out not seen in 20 cycles, expected pulse");
        end
        @(negedge clock);
        checks++;
        if (done_b !== 1'b0 || busy_b !== 1'b0 || count_b !== 32'd0) begin
            errors++;
            $display("FAIL empty_after: done=%b busy=%b count=%0d, expected 0 0 0", done_b, busy_b, count_b);
        end
        checks++;
        if (b_activity != 0) begin
            errors++;
            $display("FAIL empty_activity: %0d cycles with request or char, expected 0", b_activity);
        end
    endtask

    task automatic test_reset_midstream();
        bit seen;
        clear_stats();
        push_expected();
        start_run("mid_reset");
        seen = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clock);
            if (row_addr_out == 4'd1 && char_valid && char_out != 8'h0A) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL mid_reset_reach: row 1 emit not reached, expected within 4000 cycles");
        end
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if ({read_en_out, char_valid, done_out, busy_out, row_addr_out, col_addr_out,
             char_out, roll_count_out} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: en=%b v=%b b=%b row=%0d ch=%02h cnt=%0d, expected all 0",
                     read_en_out, char_valid, busy_out, row_addr_out, char_out, roll_count_out);
        end
        exp_q.delete();
        @(negedge clock);
        clear_stats();
        reset = 1'b1;
        push_expected();
        start_run("after_reset");
        wait_done("after_reset");
        check_run_result("after_reset");
    endtask

    task automatic test_run_while_busy();
        clear_stats();
        push_expected();
        start_run("busy_run");
        repeat (5) @(negedge clock);
        run = 1'b1;
        @(negedge clock);
        run = 1'b0;
        repeat (20) @(negedge clock);
        run = 1'b1;
        @(negedge clock);
        run = 1'b0;
        wait_done("busy_run");
        check_run_result("busy_run");
    endtask

    initial begin
        for (int r = 0; r < 16; r++) begin
            mem[r][0] = 8'h00;
            mem[r][1] = 8'h00;
        end
        mem[0][0] = 8'h05;
        mem[0][1] = 8'hF2;
        mem[1][1] = 8'hFC;

        test_reset();
        test_basic_stream();
        test_random_ready();
        test_slow_bank();
        test_empty_range();
        test_reset_midstream();
        test_run_while_busy();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
